// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period
// used by both the transmitter and the receiver.
package uart_pkg;

  // 100 MHz / 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line; presets to idle-high.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_pin,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[SYNC_STAGES-2:0], rx_pin};
  end

  assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with one-cycle byte/error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit after data bit 7.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);

  rx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              rx_s;
  logic              baud_tick;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_pin (rx_pin),
    .rx_s   (rx_s)
  );

  assign baud_tick = (baud_cnt == '0);

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
`else
  assign parity_err = 1'b0;
`endif

  // Every sample point is reached by counting baud_cnt down to zero, so the
  // stop sample returns to IDLE mid-stop-bit and catches a zero-gap start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= HALF_M1;
            rx_busy  <= 1'b1;
          end
        end
        START: begin
          if (!baud_tick) begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end else if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            state    <= DATA;
            bit_idx  <= '0;
            baud_cnt <= FULL_M1;
          end
        end
        DATA: begin
          if (!baud_tick) begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end else begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            baud_cnt  <= FULL_M1;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!baud_tick) begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end else begin
            parity_bit <= rx_s;
            baud_cnt   <= FULL_M1;
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          if (!baud_tick) begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end else if (!rx_s) begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end else begin
            state   <= IDLE;
            rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (parity_bit != ^shift_reg) begin
              parity_err <= 1'b1;
            end else begin
              rx_valid <= 1'b1;
              rx_byte  <= shift_reg;
            end
`else
            rx_valid <= 1'b1;
            rx_byte  <= shift_reg;
`endif
          end
        end
        BREAK: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner
// sequences; a scoreboard matches every strobe against kind, byte and cycle.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned N  = 16;
  localparam int unsigned H  = N / 2;
  localparam int unsigned SS = 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  // Cycles from the driven falling start edge to the visible strobe.
  localparam int unsigned LAT = SS + 1 + H + (9 + PBITS) * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(N), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_pin     (rx_pin),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_VALID = 0, K_FERR = 1, K_PERR = 2} kind_t;
  typedef struct {
    kind_t       kind;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        par_flip;
    int unsigned low_bits;
    int unsigned idle_bits;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] model_byte = 8'h00;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic hold(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic stop, input logic pf,
                              input int unsigned lo, input int unsigned idle);
    vec_t v;
    v.data = d; v.stop = stop; v.par_flip = pf; v.low_bits = lo; v.idle_bits = idle;
    return v;
  endfunction

  // Scoreboard entry for a frame whose start edge is driven in this cycle.
  task automatic expect_frame(input logic [7:0] d, input logic stop, input logic pf);
    exp_t e;
    e.at = cyc + LAT;
    if (!stop) begin
      e.kind = K_FERR; e.data = model_byte;
    end else if (PBITS != 0 && pf) begin
      e.kind = K_PERR; e.data = model_byte;
    end else begin
      e.kind = K_VALID; e.data = d; model_byte = d;
    end
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic pf);
    rx_pin = 1'b0;
    hold(N);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      hold(N);
    end
`ifdef UART_RX_PARITY_EN
    rx_pin = (^d) ^ pf;
    hold(N);
`else
    if (pf) $display("note: parity flip ignored in 8N1 build");
`endif
    rx_pin = stop;
    hold(N);
  endtask

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    kind_t k;
    exp_t  e;
    if (rx_valid || frame_err || parity_err) begin
      check("strobe_onehot", $countones({rx_valid, frame_err, parity_err}), 1);
      k = rx_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got kind %0d byte %0h, required no strobe (cycle %0d)",
                 k, rx_byte, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", k, e.kind);
        check("strobe_byte", rx_byte, e.data);
        check("strobe_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    vecs.push_back(mk(8'hA5, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mk(8'h00, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mk(8'hFF, 1'b1, 1'b0, 0, 2));
    vecs.push_back(mk(8'h3C, 1'b0, 1'b0, 50, 2));
    vecs.push_back(mk(8'h11, 1'b1, 1'b0, 0, 2));
`ifdef UART_RX_PARITY_EN
    vecs.push_back(mk(8'h03, 1'b1, 1'b1, 0, 2));
    vecs.push_back(mk(8'h03, 1'b1, 1'b0, 0, 2));
`endif

    // Reset state
    hold(3);
    check("rst_byte", rx_byte, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    rst = 1'b0;
    hold(4);

    // Table of frames; zero-gap entries run back to back
    foreach (vecs[i]) begin
      expect_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
      send(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
      if (vecs[i].low_bits != 0) hold(vecs[i].low_bits * N);
      rx_pin = 1'b1;
      if (vecs[i].idle_bits != 0) hold(vecs[i].idle_bits * N);
    end

    // Short low glitch: START aborts at the half-bit sample
    cnt = 0;
    rx_pin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) rx_pin = 1'b1;
      hold(1);
      if (rx_busy) cnt++;
    end
    check("glitch_busy_cycles", cnt, 8);
    check("glitch_busy_end", rx_busy, 0);
    hold(N);

    // Reset in the middle of a frame after data bit 3 of 0x77
    rx_pin = 1'b0;
    hold(N);
    for (int i = 0; i < 4; i++) begin
      rx_pin = 1'(8'h77 >> i);
      hold(N);
    end
    check("midframe_busy", rx_busy, 1);
    rx_pin = 1'b1;
    rst = 1'b1;
    hold(1);
    check("abort_byte", rx_byte, 8'h00);
    check("abort_busy", rx_busy, 0);
    check("abort_strobes", {rx_valid, frame_err, parity_err}, 0);
    rst = 1'b0;
    model_byte = 8'h00;
    hold(2 * N);

    expect_frame(8'h42, 1'b1, 1'b0);
    send(8'h42, 1'b1, 1'b0);
    hold(2 * N);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < int'(4 * LAT) && sb.size() != 0; i++) hold(1);
    check("pending_expectations", sb.size(), 0);
    check("final_busy", rx_busy, 0);
    check("final_byte", rx_byte, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive-side counterpart of the existing `uart` transmitter.
- Frame format: 8N1, with an optional parity bit (see Optional Feature).
- Runs on `clk100` and accepts host commands on a `uart_rx_pin` input (start sampler, trigger memory test).
- Presents each received byte to control logic with a one-cycle valid strobe.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit period (100 MHz / 115200). Minimum 4.
- SYNC_STAGES, 2: flip-flop stages in the rx_pin synchronizer. Minimum 2.

Ports:
- clk  in  1  system clock (clk100 domain)
- rst  in  1  synchronous reset, active-high
- rx_pin  in  1  asynchronous serial line; idle high
- rx_byte  out  8  last received byte; held until the next good frame
- rx_valid  out  1  one-cycle pulse; rx_byte is new in the same cycle
- rx_busy  out  1  high while a frame is in progress (state != IDLE)
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- parity_err  out  1  one-cycle pulse on parity mismatch; constant 0 when the macro is absent

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; synchronizer chain preset to 1.
  - rx_byte=8'h00; rx_valid=0, rx_busy=0, frame_err=0, parity_err=0.
  - bit counter=0; baud counter=0.
  - rst asserted mid-frame aborts the frame; no strobe is emitted.
- Input conditioning:
  - rx_pin passes through SYNC_STAGES FFs to give rx_s.
  - All decisions use rx_s only.
  - Latency from pin to rx_s: SYNC_STAGES cycles.
- Timing definitions:
  - H = CLKS_PER_BIT/2 (integer division).
  - N = CLKS_PER_BIT.
  - T0 = first cycle in IDLE where rx_s=0.
- States:
  - IDLE: on rx_s=0 go to START and load baud counter with H-1.
  - START: at T0+H, sample rx_s.
    - rx_s=1: glitch. Return to IDLE; no strobe of any kind.
    - rx_s=0: go to DATA, bit index 0, baud counter N-1.
  - DATA: bit i sampled at T0+H+(i+1)*N, LSB first, shifted into the shift register.
    - After i=7, go to PARITY (macro defined) or STOP.
  - PARITY: sampled at T0+H+9N.
  - STOP: sampled at T0+H+9N, or T0+H+10N when parity is enabled.
    - rx_s=1: next cycle rx_valid=1 and rx_byte=shift register.
    - rx_s=0: next cycle frame_err=1, rx_byte unchanged, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. A held-low line yields exactly one frame_err.
- Back-to-back frames:
  - On a good stop the FSM returns to IDLE in the same cycle as the stop sample, not at the end of the stop bit.
  - A start edge arriving half a bit later is therefore caught.
  - Throughput of 1 byte per 10 bit times, zero gap, is required.
- Strobes:
  - rx_valid, frame_err and parity_err are mutually exclusive and never wider than 1 cycle.
  - No consumer handshake. If the consumer misses a pulse, the byte is still readable on rx_byte until the next good frame.
- rx_busy = (state != IDLE), registered.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits; bit index is 3 bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit follows data bit 7.
  - Parity is checked against the XOR of the 8 data bits.
  - On mismatch with a good stop bit: parity_err pulses instead of rx_valid, and rx_byte is not updated.
  - On mismatch with a bad stop bit: frame_err takes priority.
- Not defined:
  - PARITY state and logic are absent.
  - parity_err is tied to 0.
  - Frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Default CLKS_PER_BIT constant, shared with the `uart` transmitter.
- One sub-module, uart_rx_sync:
  - SYNC_STAGES-deep FF chain, reset to 1.
  - Output rx_s.

Test Plan:
- CLKS_PER_BIT=16; send 0xA5 as 8N1 → single rx_valid pulse at T0+8+9*16+1 cycles; rx_byte=8'hA5; frame_err=0.
- Two frames 0x00 then 0xFF, zero idle gap → two rx_valid pulses exactly 160 cycles apart; bytes 0x00 then 0xFF.
- Low glitch of 5 cycles on an idle line → no strobe; rx_busy high for ~8 cycles, then 0.
- 0x3C with stop bit driven low, line then held low 50 bit times → one frame_err pulse; rx_byte keeps its previous value; next valid 0x11 is received correctly.
- rst asserted after data bit 3 of 0x77 → all outputs return to reset values next cycle; no strobe; the following frame 0x42 is received correctly.
- UART_RX_PARITY_EN: send 0x03 with parity bit 1 (wrong) → one parity_err pulse and rx_byte unchanged; send it with parity bit 0 → rx_valid with rx_byte=8'h03.
